// File: rtl/filter_classifier_if.sv
// Signal bundle between filter_classifier and its environment: capture input,
// replay stream, filter scores, report byte stream and result status.
interface filter_classifier_if #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int NUM_FILTERS       = 2,
    parameter int MATCH_SCORE_WIDTH = 32
);
    localparam int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    logic                                   trigger;
    logic                                   axiiv;
    logic [SAMPLE_DATA_WIDTH-1:0]           axiid;
    logic                                   filt_axiov;
    logic [SAMPLE_DATA_WIDTH-1:0]           filt_axiod;
    logic [NUM_FILTERS-1:0]                 score_axiiv;
    logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] score_axiid;
    logic                                   tx_axiov;
    logic [7:0]                             tx_axiod;
    logic                                   tx_axiready;
    logic                                   busy;
    logic                                   result_valid;
    logic [IDX_W-1:0]                       result_index;
    logic [MATCH_SCORE_WIDTH-1:0]           result_score;

    modport master (
        output trigger, axiiv, axiid, score_axiiv, score_axiid, tx_axiready,
        input  filt_axiov, filt_axiod, tx_axiov, tx_axiod, busy,
               result_valid, result_index, result_score
    );

    modport slave (
        input  trigger, axiiv, axiid, score_axiiv, score_axiid, tx_axiready,
        output filt_axiov, filt_axiod, tx_axiov, tx_axiod, busy,
               result_valid, result_index, result_score
    );
endinterface

// File: rtl/filter_classifier.sv
// Capture a sample burst, replay it to external matched filters for several
// passes, keep each filter's signed peak score and report the argmax as bytes.
module filter_classifier #(
    parameter int SAMPLE_DATA_WIDTH = 8,
    parameter int CAPTURE_LENGTH    = 1000,
    parameter int NUM_FILTERS       = 2,
    parameter int MATCH_SCORE_WIDTH = 32,
    parameter int NUM_PASSES        = 2001,
    parameter int SCORE_DRAIN       = 8
) (
    input logic               clk,
    input logic               rst,
    filter_classifier_if.slave bus
);
    localparam int SDW = SAMPLE_DATA_WIDTH;
    localparam int MSW = MATCH_SCORE_WIDTH;
    localparam int IW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int WW  = $clog2(CAPTURE_LENGTH + 1);
    localparam int RW  = $clog2(CAPTURE_LENGTH + 2);
    localparam int PW  = $clog2(NUM_PASSES + 1);
    localparam int AW  = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
    localparam int DW  = (SCORE_DRAIN > 1) ? $clog2(SCORE_DRAIN) : 1;
    localparam int NB  = 2 + MSW / 8;
    localparam int BW  = $clog2(NB);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DRAIN, S_REPORT} state_t;
    state_t state_q, state_d;

    logic [SDW-1:0]        mem [CAPTURE_LENGTH];
    logic [WW-1:0]         wr_q, wr_d;
    logic [RW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         pass_q, pass_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [BW-1:0]         byte_q, byte_d;
    logic [AW-1:0]         rd_addr;
    logic [SDW-1:0]        rdata1_q, rdata2_q;
    logic [1:0]            rvld_q;
    logic signed [MSW-1:0] peak_q [NUM_FILTERS];
    logic signed [MSW-1:0] peak_d [NUM_FILTERS];
    logic signed [MSW-1:0] sc;
    logic                  result_valid_q, result_valid_d;
    logic [IW-1:0]         result_index_q, best_idx;
    logic signed [MSW-1:0] result_score_q, best_score;
    logic                  cap_done, wrap, pass_done, drain_done, tx_valid, tx_fire, last_byte;
    logic [7:0]            tx_byte;

    assign cap_done   = bus.axiiv && (wr_q == WW'(CAPTURE_LENGTH - 1));
    assign wrap       = (rd_q == RW'(CAPTURE_LENGTH + 1));
    assign pass_done  = wrap && (pass_q == PW'(NUM_PASSES - 1));
    assign drain_done = (drain_q == '0);
    assign tx_fire    = tx_valid && bus.tx_axiready;
    assign last_byte  = (byte_q == BW'(NB - 1));
    assign rd_addr    = (rd_q < RW'(CAPTURE_LENGTH)) ? rd_q[AW-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.trigger)         state_d = S_CAPTURE;
            S_CAPTURE: if (cap_done)            state_d = S_REPLAY;
            S_REPLAY:  if (pass_done)           state_d = S_DRAIN;
            S_DRAIN:   if (drain_done)          state_d = S_REPORT;
            S_REPORT:  if (tx_fire && last_byte) state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Packet: sync byte, zero-extended index, score bytes MSB first
    always_comb begin
        tx_valid = (state_q == S_REPORT);
        tx_byte  = 8'h00;
        if (state_q == S_REPORT) begin
            if (byte_q == '0)
                tx_byte = 8'hA5;
            else if (byte_q == BW'(1))
                tx_byte = {{(8 - IW){1'b0}}, result_index_q};
            else
                tx_byte = 8'($unsigned(result_score_q) >> (8 * (NB - 1 - int'(byte_q))));
        end
    end

    always_comb begin
        wr_d           = wr_q;
        rd_d           = rd_q;
        pass_d         = pass_q;
        drain_d        = drain_q;
        byte_d         = byte_q;
        result_valid_d = result_valid_q;
        sc             = '0;
        for (int i = 0; i < NUM_FILTERS; i++) peak_d[i] = peak_q[i];
        case (state_q)
            S_IDLE: begin
                wr_d = '0;
                if (bus.trigger) result_valid_d = 1'b0;
            end
            S_CAPTURE: begin
                if (bus.axiiv) wr_d = wr_q + 1'b1;
                rd_d   = '0;
                pass_d = '0;
                if (cap_done)
                    for (int i = 0; i < NUM_FILTERS; i++) peak_d[i] = {1'b1, {(MSW - 1){1'b0}}};
            end
            S_REPLAY: begin
                rd_d    = wrap ? '0 : rd_q + 1'b1;
                drain_d = DW'(SCORE_DRAIN - 1);
                if (wrap) pass_d = pass_q + 1'b1;
            end
            S_DRAIN: begin
                byte_d = '0;
                if (!drain_done) drain_d = drain_q - 1'b1;
            end
            S_REPORT: begin
                if (tx_fire) begin
                    byte_d = byte_q + 1'b1;
                    if (last_byte) result_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (state_q == S_REPLAY || state_q == S_DRAIN) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                sc = $signed(bus.score_axiid[i*MSW +: MSW]);
                if (bus.score_axiiv[i] && (sc > peak_q[i])) peak_d[i] = sc;
            end
        end
    end

    // Argmax over the updated peaks so the last drain-cycle score still counts
    always_comb begin
        best_idx   = '0;
        best_score = peak_d[0];
        for (int i = 1; i < NUM_FILTERS; i++) begin
            if (peak_d[i] > best_score) begin
                best_score = peak_d[i];
                best_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_CAPTURE && bus.axiiv) mem[wr_q[AW-1:0]] <= bus.axiid;
        rdata1_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q           <= '0;
            rd_q           <= '0;
            pass_q         <= '0;
            drain_q        <= '0;
            byte_q         <= '0;
            rdata2_q       <= '0;
            rvld_q         <= '0;
            result_valid_q <= 1'b0;
            result_index_q <= '0;
            result_score_q <= '0;
            for (int i = 0; i < NUM_FILTERS; i++) peak_q[i] <= '0;
        end else begin
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            pass_q         <= pass_d;
            drain_q        <= drain_d;
            byte_q         <= byte_d;
            rdata2_q       <= rdata1_q;
            rvld_q         <= {rvld_q[0], (state_q == S_REPLAY) && (rd_q < RW'(CAPTURE_LENGTH))};
            result_valid_q <= result_valid_d;
            for (int i = 0; i < NUM_FILTERS; i++) peak_q[i] <= peak_d[i];
            if (state_q == S_DRAIN && drain_done) begin
                result_index_q <= best_idx;
                result_score_q <= best_score;
            end
        end
    end

    assign bus.filt_axiov   = rvld_q[1];
    assign bus.filt_axiod   = rvld_q[1] ? rdata2_q : '0;
    assign bus.tx_axiov     = tx_valid;
    assign bus.tx_axiod     = tx_byte;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result_index = result_index_q;
    assign bus.result_score = result_score_q;
endmodule

// File: tb/tb_filter_classifier.sv
// Randomised scoreboard bench for filter_classifier with an emulated filter bank.
module tb_filter_classifier;
    localparam int SDW = 8, CL = 4, NF = 2, W = 32, NP = 3, SD = 8, LAT = 3;

    logic clk, rst;

    filter_classifier_if #(.SAMPLE_DATA_WIDTH(SDW), .NUM_FILTERS(NF), .MATCH_SCORE_WIDTH(W)) bus ();

    filter_classifier #(
        .SAMPLE_DATA_WIDTH(SDW), .CAPTURE_LENGTH(CL), .NUM_FILTERS(NF),
        .MATCH_SCORE_WIDTH(W), .NUM_PASSES(NP), .SCORE_DRAIN(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [7:0] exp_beats[$];
    logic [7:0] exp_bytes[$];
    int model_peak[NF];
    bit mon_en = 0, noise_en = 0, bp_mode = 0;
    int score_mode = 0, beats_seen = 0, bp_cnt = 0;
    int run_len = 0, gap = 0;
    bit prev_v = 0, have_burst = 0, tx_pending = 0;
    logic [7:0] tx_held = '0;
    logic [NF-1:0]   pipe_v [LAT];
    logic [NF*W-1:0] pipe_d [LAT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Emulated filter: each replay beat yields one score per filter, LAT cycles later
    function automatic void gen(output logic [NF-1:0] v, output logic [NF*W-1:0] d);
        v = '0;
        d = '0;
        for (int f = 0; f < NF; f++) begin
            case (score_mode)
                0: begin
                    v[f] = 1'b1;
                    if (f == 0) d[f*W +: W] = (beats_seen == 5) ? 32'd5 : 32'($urandom_range(0, 4));
                    else        d[f*W +: W] = (beats_seen == 7) ? 32'd9 : 32'($urandom_range(0, 8));
                end
                1: begin
                    v[f] = 1'b1;
                    if (f == 0) d[f*W +: W] = 32'(-7);
                    else        d[f*W +: W] = (beats_seen == 3) ? 32'(-3) : 32'(-4 - int'($urandom_range(0, 50)));
                end
                2: begin
                    v[f] = 1'b1;
                    d[f*W +: W] = 32'd4;
                end
                default: begin
                    v[f] = 1'($urandom_range(0, 1));
                    d[f*W +: W] = $urandom;
                end
            endcase
        end
    endfunction

    always @(negedge clk) begin : score_drv
        logic [NF-1:0]   v;
        logic [NF*W-1:0] d;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        if (mon_en && bus.filt_axiov) gen(v, d);
        else begin v = '0; d = '0; end
        pipe_v[0] = v;
        pipe_d[0] = d;
        if (pipe_v[LAT-1] != '0) begin
            bus.score_axiiv = pipe_v[LAT-1];
            bus.score_axiid = pipe_d[LAT-1];
            for (int f = 0; f < NF; f++)
                if (pipe_v[LAT-1][f] && ($signed(pipe_d[LAT-1][f*W +: W]) > model_peak[f]))
                    model_peak[f] = int'($signed(pipe_d[LAT-1][f*W +: W]));
        end else if (noise_en) begin
            bus.score_axiiv = '1;
            bus.score_axiid = {NF{32'h7FFF_FFFF}};
        end else begin
            bus.score_axiiv = '0;
            bus.score_axiid = '0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            if (bus.tx_axiov && bp_cnt < 5) begin bus.tx_axiready = 1'b0; bp_cnt++; end
            else if (bus.tx_axiov)          begin bus.tx_axiready = 1'b1; bp_cnt = 0; end
            else                            begin bus.tx_axiready = 1'b0; bp_cnt = 0; end
        end else begin
            bus.tx_axiready = 1'b1;
        end
    end

    // Monitor: replay beats, pass framing and report bytes
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.filt_axiov) begin
                if (!prev_v && have_burst) chk("pass_gap_ge2", 64'(gap >= 2), 1);
                run_len++;
                if (exp_beats.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL replay_beat: unexpected beat %0h, none required", bus.filt_axiod);
                end else begin
                    chk("replay_beat", bus.filt_axiod, exp_beats.pop_front());
                end
                beats_seen++;
            end else begin
                if (prev_v) begin
                    chk("pass_len", run_len, CL);
                    run_len = 0; have_burst = 1; gap = 0;
                end
                gap++;
            end
            prev_v = bus.filt_axiov;
            if (tx_pending) begin
                chk("tx_hold_valid", bus.tx_axiov, 1);
                chk("tx_hold_data", bus.tx_axiod, tx_held);
            end
            tx_pending = 0;
            if (bus.tx_axiov) begin
                if (bus.tx_axiready) begin
                    if (exp_bytes.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL tx_byte: unexpected byte %0h, none required", bus.tx_axiod);
                    end else begin
                        chk("tx_byte", bus.tx_axiod, exp_bytes.pop_front());
                    end
                end else begin
                    tx_pending = 1;
                    tx_held = bus.tx_axiod;
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_filt_axiov", bus.filt_axiov, 0);
        chk("rst_filt_axiod", bus.filt_axiod, 0);
        chk("rst_tx_axiov", bus.tx_axiov, 0);
        chk("rst_tx_axiod", bus.tx_axiod, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_result_index", bus.result_index, 0);
        chk("rst_result_score", bus.result_score, 0);
        exp_beats.delete();
        exp_bytes.delete();
        for (int i = 0; i < LAT; i++) begin pipe_v[i] = '0; pipe_d[i] = '0; end
        run_len = 0; gap = 0; prev_v = 0; have_burst = 0; tx_pending = 0;
        mon_en = 1;
    endtask

    task automatic run_op(input logic [7:0] smp[CL], input bit sparse, input int smode, input bit bp,
                          input bit trig_busy, input bit mid_reset, input int fix_idx,
                          input logic [31:0] fix_score);
        int t, ei;
        logic [31:0] es;
        score_mode = smode;
        bp_mode = bp;
        beats_seen = 0;
        for (int f = 0; f < NF; f++) model_peak[f] = -2147483647 - 1;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < CL; k++) exp_beats.push_back(smp[k]);
        @(posedge clk); #1;
        bus.trigger = 1'b1; bus.axiiv = 1'b1; bus.axiid = 8'hEE; noise_en = 1;
        @(posedge clk); #1;
        bus.trigger = 1'b0;
        chk("rv_clear_on_trigger", bus.result_valid, 0);
        chk("busy_after_trigger", bus.busy, 1);
        for (int k = 0; k < CL; k++) begin
            if (sparse) begin
                bus.axiiv = 1'b0; bus.axiid = 8'hCC;
                @(posedge clk); #1;
            end
            bus.axiiv = 1'b1; bus.axiid = smp[k];
            bus.trigger = trig_busy && (k == 1);
            @(posedge clk); #1;
            bus.trigger = 1'b0;
        end
        noise_en = 0;
        bus.axiid = 8'hDD;
        t = 0;
        while (beats_seen < CL * NP && t < 400) begin
            @(posedge clk); #1;
            t++;
            if (t == 2) bus.axiiv = 1'b0;
            bus.trigger = trig_busy && (beats_seen >= 2) && (beats_seen < 4);
            if (mid_reset && beats_seen >= CL + 1) begin
                bus.trigger = 1'b0; bus.axiiv = 1'b0;
                do_reset();
                return;
            end
        end
        bus.trigger = 1'b0; bus.axiiv = 1'b0;
        chk("replay_beat_count", beats_seen, CL * NP);
        repeat (LAT + 2) @(posedge clk);
        #1;
        ei = 0;
        for (int f = 1; f < NF; f++) if (model_peak[f] > model_peak[ei]) ei = f;
        es = model_peak[ei];
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'(ei));
        for (int b = W / 8 - 1; b >= 0; b--) exp_bytes.push_back(es[b*8 +: 8]);
        t = 0;
        while (exp_bytes.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("packet_complete", exp_bytes.size(), 0);
        @(posedge clk); #1;
        chk("result_valid", bus.result_valid, 1);
        chk("busy_idle", bus.busy, 0);
        chk("result_index", bus.result_index, ei);
        chk("result_score", bus.result_score, es);
        if (fix_idx >= 0) begin
            chk("plan_index", bus.result_index, fix_idx);
            chk("plan_score", bus.result_score, fix_score);
        end
        if (trig_busy) begin
            repeat (20) @(posedge clk);
            #1;
            chk("no_restart_busy", bus.busy, 0);
            chk("result_valid_holds", bus.result_valid, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s [CL];
        rst = 1'b1;
        bus.trigger = 1'b0; bus.axiiv = 1'b0; bus.axiid = '0;
        bus.score_axiiv = '0; bus.score_axiid = '0; bus.tx_axiready = 1'b1;
        for (int i = 0; i < LAT; i++) begin pipe_v[i] = '0; pipe_d[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        s = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_op(s, 0, 0, 0, 0, 0, 1, 32'd9);
        for (int k = 0; k < CL; k++) s[k] = 8'($urandom);
        run_op(s, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFD);
        run_op(s, 0, 2, 0, 0, 0, 0, 32'd4);
        for (int k = 0; k < CL; k++) s[k] = 8'($urandom);
        run_op(s, 1, 3, 0, 0, 0, -1, 32'd0);
        for (int k = 0; k < CL; k++) s[k] = 8'($urandom);
        run_op(s, 0, 3, 1, 0, 0, -1, 32'd0);
        s = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_op(s, 0, 0, 0, 1, 0, 1, 32'd9);
        for (int k = 0; k < CL; k++) s[k] = 8'($urandom);
        run_op(s, 0, 3, 0, 0, 1, -1, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("idle_after_reset", bus.busy, 0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < CL; k++) s[k] = 8'($urandom);
            run_op(s, 1'($urandom_range(0, 1)), 3, 1'($urandom_range(0, 1)), 0, 0, -1, 32'd0);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("beats_left_over", exp_beats.size(), 0);
        chk("bytes_left_over", exp_bytes.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/filter_classifier.md
Name: filter_classifier

Overview:
Parametrised successor to the single-shot capture/filter manager. On a trigger it captures CAPTURE_LENGTH samples, then replays the buffer NUM_PASSES times as a sample stream to NUM_FILTERS external matched filters. It tracks the signed peak score of each filter and selects the best filter (argmax). The result is sent as a framed byte packet on a ready/valid byte port that feeds the UART.

Parameters:
SAMPLE_DATA_WIDTH, 8, width of each captured sample
CAPTURE_LENGTH, 1000, number of samples per capture and per replay pass
NUM_FILTERS, 2, number of matched-filter score inputs (1..16)
MATCH_SCORE_WIDTH, 32, signed score width; must be a multiple of 8
NUM_PASSES, 2001, number of replay passes per capture (>=1)
SCORE_DRAIN, 8, idle cycles after the last pass before scores freeze, covering filter latency

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
trigger  in  1  start capture; sampled only in IDLE
axiiv  in  1  input sample valid
axiid  in  SAMPLE_DATA_WIDTH  input sample
filt_axiov  out  1  replay sample valid, broadcast to all filters
filt_axiod  out  SAMPLE_DATA_WIDTH  replay sample
score_axiiv  in  NUM_FILTERS  per-filter score valid
score_axiid  in  NUM_FILTERS*MATCH_SCORE_WIDTH  packed signed scores; filter i occupies bits [i*W +: W]
tx_axiov  out  1  report byte valid
tx_axiod  out  8  report byte
tx_axiready  in  1  downstream ready
busy  out  1  high in every state except IDLE
result_valid  out  1  result fields valid
result_index  out  max(1,$clog2(NUM_FILTERS))  winning filter
result_score  out  MATCH_SCORE_WIDTH  winning peak score

Behaviour:
- Reset values: filt_axiov=0, filt_axiod=0, tx_axiov=0, tx_axiod=0, busy=0, result_valid=0, result_index=0, result_score=0. State goes to IDLE and all counters and peaks are cleared. Reset mid-operation aborts immediately and sends no partial packet.
- States: IDLE, CAPTURE, REPLAY, DRAIN, REPORT.
- IDLE: trigger=1 -> CAPTURE. result_valid clears in the same transition. Write address=0.
- CAPTURE: each axiiv=1 cycle writes axiid to the RAM at the write address, then increments it. Cycles with axiiv=0 write nothing and do not advance. After the write of sample CAPTURE_LENGTH-1, go to REPLAY. Triggers are ignored while busy.
- Capture RAM: true dual-port, read-first, 2-cycle read latency (HIGH_PERFORMANCE).
- REPLAY: the read counter runs 0..CAPTURE_LENGTH+1 each pass. Addresses 0..CAPTURE_LENGTH-1 produce filt_axiov=1 exactly 2 cycles later, with filt_axiod = RAM data, contiguous with no bubbles. This gives exactly CAPTURE_LENGTH valid beats per pass, then at least 2 cycles of filt_axiov=0 between passes.
- Pass counter: increments at counter wrap. After pass NUM_PASSES-1 has wrapped and its final valid beat has emitted -> DRAIN.
- Peak tracking: on entry to REPLAY, every peak[i] is set to the most negative value. Each cycle in REPLAY or DRAIN with score_axiiv[i]=1 applies peak[i] <= (score_i >$signed peak[i]) ? score_i : peak[i]. Scores outside REPLAY/DRAIN are ignored.
- DRAIN: SCORE_DRAIN cycles, peak tracking still active, then -> REPORT.
- Argmax: computed combinationally or in a pipelined manner on entry to REPORT. It picks the strictly largest signed peak; ties go to the lowest index. result_index and result_score are latched at REPORT entry.
- REPORT packet, in order: 0xA5, result_index zero-extended to 8 bits, then MATCH_SCORE_WIDTH/8 score bytes MSB first.
- Byte handshake: tx_axiov is held high with tx_axiod stable until a cycle with tx_axiov && tx_axiready. The next byte may be presented on the following cycle.
- After the last byte is accepted: -> IDLE, result_valid=1. result_valid holds until the next accepted trigger or rst.
- Width rules: the write counter is $clog2(CAPTURE_LENGTH+1) bits. The read counter is $clog2(CAPTURE_LENGTH+2) bits. The pass counter is $clog2(NUM_PASSES+1) bits. All score comparisons are signed.
- Capture input is not back-pressured; samples arriving outside CAPTURE are dropped.

Test Plan:
- Basic: CAPTURE_LENGTH=4, NUM_PASSES=3, NUM_FILTERS=2; capture 0x11,0x22,0x33,0x44; filter scores peak at 5 (f0) and 9 (f1) -> 3 passes of 4 contiguous beats 11,22,33,44 with >=2-cycle gaps; packet A5 01 00 00 00 09; result_index=1.
- Signed/tie: all f0 scores -7, f1 scores max -3 -> winner 1, score FFFFFFFD. Rerun with both peaks equal at 4 -> result_index=0.
- Sparse input: axiiv toggled every other cycle during capture -> replay order exactly matches the 4 valid samples; invalid-cycle data is never stored.
- Backpressure: tx_axiready low 5 cycles per byte -> each byte held stable, no byte dropped or duplicated; 6 bytes total.
- Trigger while busy: trigger pulses during CAPTURE and REPLAY -> ignored, exactly one packet; trigger in IDLE afterwards clears result_valid and restarts.
- Reset mid-REPLAY: rst asserted on pass 2 -> next cycle all outputs at reset values, busy=0, no tx_axiov; a new trigger completes normally.
